inst_fetch_buffer: RTL and testbench

//   Dual-issue instruction queue between the fetch stage and the decoder bank
//   (decoder_* units). Holds {pc, inst} pairs in program order.

---
 rtl/inst_fetch_buffer.sv | 149 ++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction queue between fetch and the decoder bank.
// Holds {pc, inst} pairs in program order. Takes up to two entries per cycle
// from fetch, shows the two oldest to decode, and retires 0, 1 or 2 per cycle.
// Flush empties the queue on a redirect. Occupancy comes from the count
// register, not from the pointer difference.
module inst_fetch_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [31:0]      in_pc0,
    input  logic [31:0]      in_inst0,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst1,
    output logic             in_ready,
    output logic [1:0]       out_valid,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst1,
    input  logic [1:0]       dec_accept,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    // Ready needs room for two entries. The limit is DEPTH-2 so that the
    // comparison never goes negative.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    // Storage and pointers
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Per-cycle control
    logic [1:0]       enq_n;
    logic [1:0]       deq_n;
    logic [1:0]       deq_mask;
    logic             wr0_en;
    logic             wr1_en;
    logic [PTR_W-1:0] wr0_idx;
    logic [PTR_W-1:0] wr1_idx;
    logic [PTR_W-1:0] head1_idx;

    // Status outputs come only from registered count, so dec_accept has no
    // combinational path to in_ready.
    always_comb begin
        in_ready     = (count_q <= READY_MAX);
        out_valid[0] = (count_q != '0);
        out_valid[1] = (count_q >= CNT_W'(2));
        count        = count_q;
    end

    // Head and head+1 are read straight from storage; there is no input bypass.
    always_comb begin
        head1_idx = head_q + PTR_W'(1);
        out_pc0   = pc_q[head_q];
        out_inst0 = inst_q[head_q];
        out_pc1   = pc_q[head1_idx];
        out_inst1 = inst_q[head1_idx];
    end

    // Enqueue: drop the request when not ready, and fetch retries.
    always_comb begin
        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
        enq_n   = 2'd0;
        wr0_idx = tail_q;
        wr1_idx = tail_q + PTR_W'(1);
        if (in_ready && !flush) begin
            wr0_en = in_valid[0];
            wr1_en = in_valid[1];
        end
        if (in_ready) begin
            enq_n = 2'(in_valid[0]) + 2'(in_valid[1]);
        end
    end

    // Dequeue: an accept on a slot that is not valid is ignored.
    always_comb begin
        deq_mask = dec_accept & out_valid;
        deq_n    = 2'(deq_mask[0]) + 2'(deq_mask[1]);
    end

    // Pointer and occupancy next state. Flush wins over enqueue and dequeue.
    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Storage next state: slot0 lands at tail, slot1 at tail+1.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_d[i]   = pc_q[i];
            inst_d[i] = inst_q[i];
            if (wr0_en && (wr0_idx == PTR_W'(i))) begin
                pc_d[i]   = in_pc0;
                inst_d[i] = in_inst0;
            end
            if (wr1_en && (wr1_idx == PTR_W'(i))) begin
                pc_d[i]   = in_pc1;
                inst_d[i] = in_inst1;
            end
        end
    end

    // Control state registers; reset also covers a flush in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so empty outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= pc_d[i];
                inst_q[i] <= inst_d[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed vector table, hand
// sequences for flush and async reset, and a random run against a queue model.
module tb_inst_fetch_buffer;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
    logic [1:0]  dec_accept;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    inst_fetch_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc0     (in_pc0),
        .in_inst0   (in_inst0),
        .in_pc1     (in_pc1),
        .in_inst1   (in_inst1),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_pc0    (out_pc0),
        .out_inst0  (out_inst0),
        .out_pc1    (out_pc1),
        .out_inst1  (out_inst1),
        .dec_accept (dec_accept),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Illegal slot patterns are never driven by this bench.
    always @(posedge clk) begin
        if (!rst) begin
            assert (in_valid != 2'b10) else $error("illegal in_valid 10");
            assert (dec_accept != 2'b10) else $error("illegal dec_accept 10");
        end
    end

    typedef struct {
        logic        fl;
        logic [1:0]  iv;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  da;
        logic [3:0]  cnt;
        logic [1:0]  ov;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        rdy;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t vq[$];
    ent_t mq[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5a5a_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic [1:0] iv, input logic [31:0] p0,
                         input logic [31:0] p1, input logic [1:0] da);
        flush      = fl;
        in_valid   = iv;
        in_pc0     = p0;
        in_inst0   = inst_of(p0);
        in_pc1     = p1;
        in_inst1   = inst_of(p1);
        dec_accept = da;
    endtask

    task automatic add(input logic fl, input logic [1:0] iv, input logic [31:0] p0,
                       input logic [31:0] p1, input logic [1:0] da, input logic [3:0] cnt,
                       input logic [1:0] ov, input logic [31:0] e0, input logic [31:0] e1,
                       input logic rdy);
        vec_t v;
        v.fl = fl; v.iv = iv; v.p0 = p0; v.p1 = p1; v.da = da;
        v.cnt = cnt; v.ov = ov; v.e0 = e0; v.e1 = e1; v.rdy = rdy;
        vq.push_back(v);
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic [1:0] ov,
                             input logic [31:0] e0, input logic [31:0] e1, input logic rdy);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        if (ov[0]) begin
            chk({tag, " out_pc0"}, out_pc0, e0);
            chk({tag, " out_inst0"}, out_inst0, inst_of(e0));
        end
        if (ov[1]) begin
            chk({tag, " out_pc1"}, out_pc1, e1);
            chk({tag, " out_inst1"}, out_inst1, inst_of(e1));
        end
    endtask

    // Compare DUT against the queue model at the current sample point.
    task automatic chk_model(input int cyc);
        logic [1:0] ov;
        string tag;
        tag = $sformatf("rnd%0d", cyc);
        ov  = {mq.size() >= 2, mq.size() >= 1};
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " in_ready"}, 32'(in_ready), 32'((8 - mq.size()) >= 2));
        chk({tag, " count_le_depth"}, 32'(count <= 4'd8), 32'd1);
        if (mq.size() >= 1) begin
            chk({tag, " out_pc0"}, out_pc0, mq[0].pc);
            chk({tag, " out_inst0"}, out_inst0, mq[0].inst);
        end
        if (mq.size() >= 2) begin
            chk({tag, " out_pc1"}, out_pc1, mq[1].pc);
            chk({tag, " out_inst1"}, out_inst1, mq[1].inst);
        end
    endtask

    initial begin
        logic [31:0] pcg;
        logic [1:0]  iv, da;
        logic        fl, rdy;
        int          sz;

        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);

        // Fill, full hold, drain with wrap, single-step, then flush collision.
        add(0, 2'b11, B+'h00, B+'h04, 2'b00, 2, 2'b11, B+'h00, B+'h04, 1);
        add(0, 2'b11, B+'h08, B+'h0c, 2'b00, 4, 2'b11, B+'h00, B+'h04, 1);
        add(0, 2'b11, B+'h10, B+'h14, 2'b00, 6, 2'b11, B+'h00, B+'h04, 1);
        add(0, 2'b11, B+'h18, B+'h1c, 2'b00, 8, 2'b11, B+'h00, B+'h04, 0);
        add(0, 2'b11, B+'h20, B+'h24, 2'b00, 8, 2'b11, B+'h00, B+'h04, 0);
        add(0, 2'b11, B+'h20, B+'h24, 2'b11, 6, 2'b11, B+'h08, B+'h0c, 1);
        add(0, 2'b11, B+'h20, B+'h24, 2'b11, 6, 2'b11, B+'h10, B+'h14, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b01, 5, 2'b11, B+'h14, B+'h18, 1);
        add(0, 2'b01, B+'h28, 32'h0,  2'b00, 6, 2'b11, B+'h14, B+'h18, 1);
        add(0, 2'b01, B+'h2c, 32'h0,  2'b00, 7, 2'b11, B+'h14, B+'h18, 0);
        add(0, 2'b01, B+'h30, 32'h0,  2'b00, 7, 2'b11, B+'h14, B+'h18, 0);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 5, 2'b11, B+'h1c, B+'h20, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 3, 2'b11, B+'h24, B+'h28, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 1, 2'b01, B+'h2c, 32'h0,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 0, 2'b00, 32'h0,  32'h0,  1);
        add(0, 2'b01, B+'h40, 32'h0,  2'b00, 1, 2'b01, B+'h40, 32'h0,  1);
        add(0, 2'b11, B+'h44, B+'h48, 2'b01, 2, 2'b11, B+'h44, B+'h48, 1);
        add(0, 2'b11, B+'h4c, B+'h50, 2'b11, 2, 2'b11, B+'h4c, B+'h50, 1);
        add(1, 2'b11, B+'h58, B+'h5c, 2'b11, 0, 2'b00, 32'h0,  32'h0,  1);
        add(0, 2'b11, B+'h80, B+'h84, 2'b00, 2, 2'b11, B+'h80, B+'h84, 1);
        add(0, 2'b11, B+'h88, B+'h8c, 2'b00, 4, 2'b11, B+'h80, B+'h84, 1);
        add(1, 2'b11, B+'h90, B+'h94, 2'b11, 0, 2'b00, 32'h0,  32'h0,  1);
        add(0, 2'b01, B+'h100, 32'h0, 2'b00, 1, 2'b01, B+'h100, 32'h0, 1);

        // Reset state, observed while reset is still asserted.
        #1;
        chk_state("reset", 4'd0, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("reset out_pc0 zero", out_pc0, 32'h0);
        chk("reset out_inst1 zero", out_inst1, 32'h0);
        tick;
        tick;
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].fl, vq[i].iv, vq[i].p0, vq[i].p1, vq[i].da);
            tick;
            chk_state($sformatf("vec%0d", i), vq[i].cnt, vq[i].ov, vq[i].e0, vq[i].e1,
                      vq[i].rdy);
        end

        // Build count=5 then hit rst mid-cycle: outputs must clear before the edge.
        drive(0, 2'b11, B+'h104, B+'h108, 2'b00);
        tick;
        drive(0, 2'b11, B+'h10c, B+'h110, 2'b00);
        tick;
        drive(0, 2'b00, 32'h0, 32'h0, 2'b00);
        chk_state("pre_rst", 4'd5, 2'b11, B+'h100, B+'h104, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 4'd0, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("async_rst out_pc0 zero", out_pc0, 32'h0);
        // Flush together with reset still yields the reset state.
        drive(1, 2'b11, B+'h200, B+'h204, 2'b11);
        tick;
        rst = 1'b0;
        drive(0, 2'b00, 32'h0, 32'h0, 2'b00);
        tick;
        chk_state("post_rst", 4'd0, 2'b00, 32'h0, 32'h0, 1'b1);

        // Random run against the queue model.
        mq.delete();
        pcg = B + 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            chk_model(c);
            case ($urandom_range(0, 2))
                0:       iv = 2'b00;
                1:       iv = 2'b01;
                default: iv = 2'b11;
            endcase
            // Alternate phases so the queue spends time both near full and near empty.
            if ((c % 1000) < 500) da = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            else                  da = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b01;
            fl = ($urandom_range(0, 63) == 0);
            drive(fl, iv, pcg, pcg + 32'h4, da);
            in_inst0 = $urandom;
            in_inst1 = $urandom;
            sz  = mq.size();
            rdy = ((8 - sz) >= 2);
            if (fl) begin
                mq.delete();
            end else begin
                if (da[0] && sz >= 1) void'(mq.pop_front());
                if (da[1] && sz >= 2) void'(mq.pop_front());
                if (rdy && iv[0]) begin
                    mq.push_back('{pc: in_pc0, inst: in_inst0});
                    pcg = pcg + 32'h4;
                end
                if (rdy && iv[1]) begin
                    mq.push_back('{pc: in_pc1, inst: in_inst1});
                    pcg = pcg + 32'h4;
                end
            end
            tick;
        end
        drive(0, 2'b00, 32'h0, 32'h0, 2'b00);
        chk_model(10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
